disp_arbiter: RTL and testbench
===============================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16: requester data width.
REQ-002 SHALL have parameter HOLD_CYCLES, default 200000000: number of cycles the step value stays on the display after a step write; legal range is 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cnt_req, input, 1 bit: count requester wants a display write; held high until granted.
REQ-006 SHALL have port cnt_data, input, DATA_W bits: count value; stable while cnt_req is high.
REQ-007 SHALL have port cnt_gnt, output, 1 bit: one-cycle grant to the count requester.
REQ-008 SHALL have port step_req, input, 1 bit: step requester wants a display write; held high until granted.
REQ-009 SHALL have port step_data, input, DATA_W bits: step value; stable while step_req is high.
REQ-010 SHALL have port step_gnt, output, 1 bit: one-cycle grant to the step requester.
REQ-011 SHALL have port wr_en, output, 1 bit: one-cycle write strobe to the seven-segment display.
REQ-012 SHALL have port wr_data, output, 32 bits: display write data, zero-extended.
REQ-013 SHALL have port show_step, output, 1 bit: high while the display holds a step value.

Function
REQ-014 SHALL implement the FSM states IDLE, WR_CNT, WR_STEP, HOLD and FLUSH, all registered.
REQ-015 In IDLE, a single request SHALL move to WR_CNT or WR_STEP on the next edge.
REQ-016 In IDLE, simultaneous requests SHALL be granted round-robin against last_gnt.
REQ-017 WR_CNT and WR_STEP SHALL each last exactly 1 cycle and assert the matching gnt, wr_en and wr_data={0,data}, so a write is visible 1 cycle after the request is sampled.
REQ-018 After a requester's gnt, the requester SHALL drop req on the next cycle; the arbiter SHALL NOT re-grant a req that is still high in the cycle after its gnt.
REQ-019 WR_CNT SHALL go to IDLE.
REQ-020 WR_STEP SHALL load the hold timer with HOLD_CYCLES and go to HOLD.
REQ-021 In HOLD with step_req high, the arbiter SHALL go to WR_STEP, which restarts the timer; step always wins over count and over timer expiry in the same cycle.
REQ-022 In HOLD with only cnt_req high, the arbiter SHALL assert cnt_gnt, latch cnt_data into pend_data, set pend_valid and issue no write; a newer count overwrites an older pending value.
REQ-023 On timer expiry in HOLD, the arbiter SHALL go to FLUSH if pend_valid, else to IDLE.
REQ-024 FLUSH SHALL assert wr_en with pend_data for 1 cycle, clear pend_valid and go to IDLE; no gnt is asserted in FLUSH.
REQ-025 show_step SHALL be high in WR_STEP and HOLD, and low otherwise.
REQ-026 The timer SHALL be $clog2(HOLD_CYCLES+1) bits wide and count down, saturating at 0.
REQ-027 cnt_gnt and step_gnt SHALL never be high in the same cycle.

Reset
REQ-028 While rst is low, the block SHALL hold state=IDLE, all gnt=0, wr_en=0, wr_data=0, show_step=0, timer=0, pend_valid=0, pend_data=0 and last_gnt=STEP, so the first tie goes to count.
REQ-029 A reset asserted mid-HOLD or mid-FLUSH SHALL discard pending data with no write issued.

Configuration
REQ-030 With macro DISP_ARB_HOLD_EN defined, the block SHALL include the HOLD/FLUSH behaviour, the timer and pend_data.
REQ-031 Without DISP_ARB_HOLD_EN, WR_STEP SHALL go directly to IDLE, HOLD and FLUSH SHALL be unreachable and removed, show_step SHALL be high only in WR_STEP, and HOLD_CYCLES SHALL be ignored.

Structure
REQ-032 Package disp_arb_pkg SHALL hold the state enum, the grant-ID encoding (CNT, STEP) and the WR_DATA_W=32 constant.
REQ-033 Sub-module hold_timer (load, load value, expire pulse) SHALL implement the countdown.

Verification (bench uses HOLD_CYCLES=4)
REQ-034 Scenario: cnt_req with cnt_data=0x0007 from IDLE -> next cycle cnt_gnt=1, wr_en=1, wr_data=0x00000007, then IDLE.
REQ-035 Scenario: cnt_req and step_req both high after reset -> count granted first (wr_data=count value), then step, show_step=1 for 1+4 cycles.
REQ-036 Scenario: step write 0x0003, then cnt_req with 0x0010 and 0x0011 during HOLD -> two cnt_gnt pulses, no wr_en until expiry, FLUSH writes 0x00000011, show_step falls.
REQ-037 Scenario: step_req arriving in the expiry cycle of HOLD -> WR_STEP, timer reloaded to 4, pending count still flushed after the new hold.
REQ-038 Scenario: rst low for 1 cycle in HOLD with pend_valid=1 -> all outputs 0 at once, no later FLUSH write.
REQ-039 Scenario: build without DISP_ARB_HOLD_EN, step then count back-to-back -> two writes on consecutive grants, show_step 1 cycle.

Source files
------------

// File: rtl/disp_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_arb_pkg: state, grant-ID and width definitions for disp_arbiter.      |
// | HOLD/FLUSH states exist only when DISP_ARB_HOLD_EN is defined.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package disp_arb_pkg;

    localparam int WR_DATA_W = 32;

    typedef enum logic {
        CNT  = 1'b0,
        STEP = 1'b1
    } gnt_id_t;

`ifdef DISP_ARB_HOLD_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CNT  = 3'd1,
        WR_STEP = 3'd2,
        HOLD    = 3'd3,
        FLUSH   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_CNT  = 2'd1,
        WR_STEP = 2'd2
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/disp_arbiter_hold_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hold_timer: loadable down-counter that saturates at zero and pulses        |
// | expire during the last counted cycle.                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 200000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [$clog2(HOLD_CYCLES+1)-1:0] load_val,
    output logic                             expire
);

    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A load of N yields exactly N cycles before expiry is acted upon.
    assign expire = (count == TIMER_W'(1));

endmodule
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_arbiter: round-robin arbiter for count/step writes to a 7-seg display.|
// | Define DISP_ARB_HOLD_EN to keep step values up for HOLD_CYCLES cycles.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned HOLD_CYCLES = 200000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt_req,
    input  logic [DATA_W-1:0]    cnt_data,
    output logic                 cnt_gnt,
    input  logic                 step_req,
    input  logic [DATA_W-1:0]    step_data,
    output logic                 step_gnt,
    output logic                 wr_en,
    output logic [WR_DATA_W-1:0] wr_data,
    output logic                 show_step
);

    state_t  state;
    state_t  next_state;
    gnt_id_t last_gnt;
    logic    cnt_mask;
    logic    step_mask;
    logic    cnt_ok;
    logic    step_ok;

    // A request still high in the cycle right after its grant is stale.
    assign cnt_ok  = cnt_req  & ~cnt_mask;
    assign step_ok = step_req & ~step_mask;

`ifdef DISP_ARB_HOLD_EN
    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);

    logic              timer_load;
    logic              expire;
    logic              pend_load;
    logic              pend_valid;
    logic [DATA_W-1:0] pend_data;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (timer_load),
        .load_val (TIMER_W'(HOLD_CYCLES)),
        .expire   (expire)
    );
`else
    logic unused_hold_cycles;
    assign unused_hold_cycles = (HOLD_CYCLES != 0);
`endif

    always_comb begin
        next_state = state;
        cnt_gnt    = 1'b0;
        step_gnt   = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        show_step  = 1'b0;
`ifdef DISP_ARB_HOLD_EN
        timer_load = 1'b0;
        pend_load  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cnt_ok && step_ok) begin
                    next_state = (last_gnt == STEP) ? WR_CNT : WR_STEP;
                end else if (cnt_ok) begin
                    next_state = WR_CNT;
                end else if (step_ok) begin
                    next_state = WR_STEP;
                end
            end
            WR_CNT: begin
                cnt_gnt    = 1'b1;
                wr_en      = 1'b1;
                wr_data    = WR_DATA_W'(cnt_data);
                next_state = IDLE;
            end
            WR_STEP: begin
                step_gnt   = 1'b1;
                wr_en      = 1'b1;
                wr_data    = WR_DATA_W'(step_data);
                show_step  = 1'b1;
`ifdef DISP_ARB_HOLD_EN
                timer_load = 1'b1;
                next_state = HOLD;
`else
                next_state = IDLE;
`endif
            end
`ifdef DISP_ARB_HOLD_EN
            HOLD: begin
                show_step = 1'b1;
                if (step_ok) begin
                    next_state = WR_STEP;
                end else begin
                    // Count is acknowledged now but parked until the hold ends.
                    if (cnt_ok) begin
                        cnt_gnt   = 1'b1;
                        pend_load = 1'b1;
                    end
                    if (expire) begin
                        next_state = (pend_valid || cnt_ok) ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                wr_en      = 1'b1;
                wr_data    = WR_DATA_W'(pend_data);
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_gnt  <= STEP;
            cnt_mask  <= 1'b0;
            step_mask <= 1'b0;
        end else begin
            state     <= next_state;
            cnt_mask  <= cnt_gnt;
            step_mask <= step_gnt;
            if (cnt_gnt) begin
                last_gnt <= CNT;
            end else if (step_gnt) begin
                last_gnt <= STEP;
            end
        end
    end

`ifdef DISP_ARB_HOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (pend_load) begin
            pend_valid <= 1'b1;
            pend_data  <= cnt_data;
        end else if (state == FLUSH) begin
            pend_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_disp_arbiter: vector table, scenario sequences and random traffic       |
// | against a behavioural model; follows DISP_ARB_HOLD_EN like the DUT.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_disp_arbiter;

    localparam int DW = 16;
    localparam int H  = 4;
`ifdef DISP_ARB_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    localparam int A_NONE  = 0;
    localparam int A_CNT   = 1;
    localparam int A_STEP  = 2;
    localparam int A_FLUSH = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnt_req;
    logic [DW-1:0] cnt_data;
    logic          cnt_gnt;
    logic          step_req;
    logic [DW-1:0] step_data;
    logic          step_gnt;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic          show_step;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disp_arbiter #(
        .DATA_W      (DW),
        .HOLD_CYCLES (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_req   (cnt_req),
        .cnt_data  (cnt_data),
        .cnt_gnt   (cnt_gnt),
        .step_req  (step_req),
        .step_data (step_data),
        .step_gnt  (step_gnt),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .show_step (show_step)
    );

    typedef struct {
        logic          rst;
        logic          cr;
        logic [DW-1:0] cd;
        logic          sr;
        logic [DW-1:0] sd;
        logic          cg;
        logic          sg;
        logic          we;
        logic [31:0]   wd;
        logic          ss;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic cr, input logic [DW-1:0] cd,
                                input logic sr, input logic [DW-1:0] sd,
                                input logic cg, input logic sg, input logic we,
                                input logic [31:0] wd, input logic ss);
        vec_t v;
        v.rst = r;  v.cr = cr; v.cd = cd; v.sr = sr; v.sd = sd;
        v.cg  = cg; v.sg = sg; v.we = we; v.wd = wd; v.ss = ss;
        return v;
    endfunction

    function automatic logic [35:0] outs();
        return {cnt_gnt, step_gnt, wr_en, wr_data, show_step};
    endfunction

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cg=%b sg=%b we=%b wd=%h ss=%b, expected cg=%b sg=%b we=%b wd=%h ss=%b",
                     name, got[35], got[34], got[33], got[32:1], got[0],
                     exp[35], exp[34], exp[33], exp[32:1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1; outputs are sampled on the falling edge.
    task automatic run_vec(input vec_t v, input string name);
        rst       = v.rst;
        cnt_req   = v.cr;
        cnt_data  = v.cd;
        step_req  = v.sr;
        step_data = v.sd;
        @(negedge clk);
        check(name, outs(), {v.cg, v.sg, v.we, v.wd, v.ss});
        @(posedge clk);
        #1;
    endtask

    // Reference model: a write scheduled for the current cycle, the number of
    // step-display cycles still owed, and at most one parked count value.
    int            m_act;
    logic [31:0]   m_act_data;
    int            m_hold;
    bit            m_pend_v;
    logic [DW-1:0] m_pend;
    bit            m_last_step;
    bit            m_block_c;
    bit            m_block_s;
    bit            e_cg, e_sg, e_we, e_ss;
    logic [31:0]   e_wd;

    task model_eval();
        bit c, s;
        c = cnt_req && !m_block_c;
        s = step_req && !m_block_s;
        e_cg = 1'b0; e_sg = 1'b0; e_we = 1'b0; e_wd = '0; e_ss = 1'b0;
        case (m_act)
            A_CNT:   begin e_cg = 1'b1; e_we = 1'b1; e_wd = m_act_data; end
            A_STEP:  begin e_sg = 1'b1; e_we = 1'b1; e_wd = m_act_data; e_ss = 1'b1; end
            A_FLUSH: begin e_we = 1'b1; e_wd = {16'h0000, m_pend}; end
            default: begin
                if (m_hold > 0) begin
                    e_ss = 1'b1;
                    if (c && !s) e_cg = 1'b1;
                end
            end
        endcase
    endtask

    task model_advance();
        bit c, s;
        int nxt;
        c   = cnt_req && !m_block_c;
        s   = step_req && !m_block_s;
        nxt = A_NONE;
        if (m_act == A_STEP) begin
            m_hold = HOLD_ON ? H : 0;
        end else if (m_act == A_FLUSH) begin
            m_pend_v = 1'b0;
        end else if (m_act == A_NONE && m_hold > 0) begin
            if (s) begin
                nxt        = A_STEP;
                m_act_data = 32'(step_data);
                m_hold     = 0;
            end else begin
                if (c) begin
                    m_pend   = cnt_data;
                    m_pend_v = 1'b1;
                end
                m_hold--;
                if (m_hold == 0 && m_pend_v) nxt = A_FLUSH;
            end
        end else if (m_act == A_NONE) begin
            if (c && (!s || m_last_step)) begin
                nxt        = A_CNT;
                m_act_data = 32'(cnt_data);
            end else if (s) begin
                nxt        = A_STEP;
                m_act_data = 32'(step_data);
            end
        end
        m_block_c = e_cg;
        m_block_s = e_sg;
        if (e_cg)      m_last_step = 1'b0;
        else if (e_sg) m_last_step = 1'b1;
        m_act = nxt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_c, saw_s;
        int wr_seen;

        rst = 1'b0; cnt_req = 1'b0; step_req = 1'b0; cnt_data = '0; step_data = '0;
        @(posedge clk);
        #1;

        // Single count write, tie after reset, step hold window, stale request.
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0007, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0007, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h7, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0021, 1'b1, 16'h0035, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0021, 1'b1, 16'h0035, 1'b1, 1'b0, 1'b1, 32'h21, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0035, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0035, 1'b0, 1'b1, 1'b1, 32'h35, 1'b1));
        for (int k = 0; k < H; k++)
            tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, HOLD_ON));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h5, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

`ifdef DISP_ARB_HOLD_EN
        // Two counts parked during a hold; only the newer one is flushed.
        run_vec(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "pend_reset");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "pend_req");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 32'h3, 1'b1), "pend_step_wr");
        run_vec(mk(1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1), "pend_cnt_a");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1), "pend_hold");
        run_vec(mk(1'b1, 1'b1, 16'h0011, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1), "pend_cnt_b");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1), "pend_expire");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0), "pend_flush");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "pend_idle");

        // Step arriving on the expiry cycle restarts the hold; flush follows it.
        run_vec(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "exp_reset");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "exp_req");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 32'h3, 1'b1), "exp_step_wr");
        run_vec(mk(1'b1, 1'b1, 16'h0044, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1), "exp_cnt");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1), "exp_hold3");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1), "exp_hold2");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1), "exp_step_race");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0009, 1'b0, 1'b1, 1'b1, 32'h9, 1'b1), "exp_step_wr2");
        for (int k = 0; k < H; k++)
            run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1),
                    $sformatf("exp_rehold%0d", k));
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0), "exp_flush");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "exp_idle");

        // Reset pulse mid-hold with a parked count: outputs clear, nothing flushed.
        run_vec(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "rst_reset");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "rst_req");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 32'h3, 1'b1), "rst_step_wr");
        run_vec(mk(1'b1, 1'b1, 16'h0055, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1), "rst_cnt");
        cnt_req = 1'b0;
        @(negedge clk);
        check("rst_hold", outs(), {1'b0, 1'b0, 1'b0, 32'h0, 1'b1});
        #2 rst = 1'b0;
        #1 check("rst_async_clear", outs(), 36'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        wr_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
        end
        check_int("rst_no_flush", wr_seen, 0);
        @(posedge clk);
        #1;
`else
        // Step then count back to back: two writes, one-cycle step display.
        run_vec(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "b2b_reset");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "b2b_req");
        run_vec(mk(1'b1, 1'b1, 16'h0012, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 32'h3, 1'b1), "b2b_step_wr");
        run_vec(mk(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "b2b_arb");
        run_vec(mk(1'b1, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h12, 1'b0), "b2b_cnt_wr");
        run_vec(mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "b2b_idle");
`endif

        // Random traffic from two well-behaved requesters.
        run_vec(mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0), "rand_reset");
        rst         = 1'b1;
        m_act       = A_NONE;
        m_act_data  = '0;
        m_hold      = 0;
        m_pend_v    = 1'b0;
        m_pend      = '0;
        m_last_step = 1'b1;
        m_block_c   = 1'b0;
        m_block_s   = 1'b0;
        saw_c       = 1'b0;
        saw_s       = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cnt_req && saw_c) begin
                cnt_req = 1'b0;
            end else if (!cnt_req && $urandom_range(2) == 0) begin
                cnt_req  = 1'b1;
                cnt_data = 16'($urandom);
            end
            if (step_req && saw_s) begin
                step_req = 1'b0;
            end else if (!step_req && $urandom_range(3) == 0) begin
                step_req  = 1'b1;
                step_data = 16'($urandom);
            end
            @(negedge clk);
            model_eval();
            check($sformatf("rand%0d", cyc), outs(), {e_cg, e_sg, e_we, e_wd, e_ss});
            saw_c = e_cg;
            saw_s = e_sg;
            @(posedge clk);
            model_advance();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
